pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall controller for a five-stage pipeline.
// Produces stage-register load enables and bubble (flush) controls from the
// current hazard inputs. It tracks data-memory wait cycles, halts on a memory
// timeout, and keeps a saturating count of cycles in which the PC was frozen.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        ex_memtoreg,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_write_reg,
  input  logic        ex_branch_taken,
  input  logic        mem_access,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic [1:0]  state,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  // Hazard detection; a memory stall cannot exist once halted.
  always_comb begin
    mem_stall = mem_access & ~mem_ready & (state_q != HALT);
    rs1_hit   = (ex_write_reg == id_rs1);
    rs2_hit   = id_uses_rs2 & (ex_write_reg == id_rs2);
    load_use  = ex_memtoreg & ex_wr_en & (ex_write_reg != 5'd0) & (rs1_hit | rs2_hit);
  end

  // Stage enables and flushes, in priority order reset > HALT > mem_stall > branch > load_use.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == HALT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Next-state logic for the memory-wait FSM, timeout and stall counters.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;

    if (mem_stall) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt_q == WAIT_LIMIT) begin
            state_d   = HALT;
            mem_err_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          state_d = RUN;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase

    if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (TIMEOUT overridden to 4).
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_write_reg;
  logic        id_uses_rs2, ex_memtoreg, ex_wr_en, ex_branch_taken;
  logic        mem_access, mem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_flush;
  logic [1:0]  state;
  logic        mem_err;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_memtoreg(ex_memtoreg), .ex_wr_en(ex_wr_en), .ex_write_reg(ex_write_reg),
    .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .state(state), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of controls: {pc,ifid,idex,exmem,memwb enables, ifid,idex,memwb flushes}
  function automatic logic [7:0] ctl();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush};
  endfunction

  task automatic set_idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 1'b0;
    ex_memtoreg = 1'b0; ex_wr_en = 1'b0; ex_write_reg = 5'd0;
    ex_branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    ex_memtoreg = 1'b1; ex_wr_en = 1'b1; ex_write_reg = 5'd5; id_rs1 = 5'd5;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    #1;
    checks++;
    if (ctl() !== 8'b00000_111) begin
      errors++; $display("FAIL reset_ctl got %b exp %b", ctl(), 8'b00000_111);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 2'd0 || mem_err !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_regs got st=%0d err=%0b cnt=%0d exp 0 0 0", state, mem_err, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ctl() !== 8'b11111_000) begin
      errors++; $display("FAIL normal_ctl got %b exp %b", ctl(), 8'b11111_000);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 16'd0 || state !== 2'd0) begin
      errors++; $display("FAIL normal_regs got cnt=%0d st=%0d exp 0 0", stall_cnt, state);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    checks++;
    if (ctl() !== 8'b00111_010) begin
      errors++; $display("FAIL load_use_ctl got %b exp %b", ctl(), 8'b00111_010);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_cnt got %0d exp 1", stall_cnt);
    end
    @(negedge clk);
    set_idle();
    // rs2 match is ignored when the instruction does not read rs2
    ex_memtoreg = 1'b1; ex_wr_en = 1'b1; ex_write_reg = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
    #1;
    checks++;
    if (ctl() !== 8'b11111_000) begin
      errors++; $display("FAIL rs2_unused_ctl got %b exp %b", ctl(), 8'b11111_000);
    end
    id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (ctl() !== 8'b00111_010) begin
      errors++; $display("FAIL rs2_used_ctl got %b exp %b", ctl(), 8'b00111_010);
    end
    // x0 destination never creates a hazard
    ex_write_reg = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    checks++;
    if (ctl() !== 8'b11111_000) begin
      errors++; $display("FAIL x0_ctl got %b exp %b", ctl(), 8'b11111_000);
    end
    // wr_en low disables the hazard
    ex_write_reg = 5'd5; id_rs1 = 5'd5; ex_wr_en = 1'b0;
    #1;
    checks++;
    if (ctl() !== 8'b11111_000) begin
      errors++; $display("FAIL no_wr_ctl got %b exp %b", ctl(), 8'b11111_000);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL no_stall_cnt got %0d exp 1", stall_cnt);
    end
  endtask

  task automatic test_branch_load_use();
    do_reset();
    set_load_use();
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl() !== 8'b11111_110) begin
      errors++; $display("FAIL branch_ctl got %b exp %b", ctl(), 8'b11111_110);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL branch_cnt got %0d exp 0", stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    set_load_use();
    ex_branch_taken = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++;
      if (ctl() !== 8'b00001_001 || state !== 2'(i > 1)) begin
        errors++; $display("FAIL mem_wait_ctl cyc %0d got %b st=%0d exp %b st=%0d", i, ctl(), state, 8'b00001_001, (i > 1));
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    set_idle();
    mem_access = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl() !== 8'b11111_000 || state !== 2'd1) begin
      errors++; $display("FAIL mem_done_ctl got %b st=%0d exp %b st=1", ctl(), state, 8'b11111_000);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 2'd0 || stall_cnt !== 16'd3 || mem_err !== 1'b0) begin
      errors++; $display("FAIL mem_done_regs got st=%0d cnt=%0d err=%0b exp 0 3 0", state, stall_cnt, mem_err);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state !== ((i < 4) ? 2'd1 : 2'd2) || mem_err !== (i == 4)) begin
        errors++; $display("FAIL timeout_seq edge %0d got st=%0d err=%0b", i, state, mem_err);
      end
    end
    checks++;
    if (ctl() !== 8'b00000_000 || stall_cnt !== 16'd4) begin
      errors++; $display("FAIL halt_ctl got %b cnt=%0d exp %b cnt=4", ctl(), stall_cnt, 8'b00000_000);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 2'd2 || mem_err !== 1'b1 || stall_cnt !== 16'd5) begin
      errors++; $display("FAIL halt_hold got st=%0d err=%0b cnt=%0d exp 2 1 5", state, mem_err, stall_cnt);
    end
    // asynchronous reset out of HALT, mid-cycle
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || mem_err !== 1'b0 || stall_cnt !== 16'd0 || ctl() !== 8'b00000_111) begin
      errors++; $display("FAIL halt_async_rst got st=%0d err=%0b cnt=%0d ctl=%b", state, mem_err, stall_cnt, ctl());
    end
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    @(posedge clk); #1;
    checks++;
    if (state !== 2'd0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL post_rst got st=%0d cnt=%0d exp 0 0", state, stall_cnt);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (pc_en !== 1'b1 || state !== 2'd1) begin
      errors++; $display("FAIL boundary_ctl got pc_en=%0b st=%0d exp 1 1", pc_en, state);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 2'd0 || mem_err !== 1'b0 || stall_cnt !== 16'd3) begin
      errors++; $display("FAIL boundary_regs got st=%0d err=%0b cnt=%0d exp 0 0 3", state, mem_err, stall_cnt);
    end
    // a fresh wait starts counting from zero again
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state !== 2'd1 || mem_err !== 1'b0) begin
      errors++; $display("FAIL rewait got st=%0d err=%0b exp 1 0", state, mem_err);
    end
  endtask

  task automatic test_async_rst_wait();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL wait_async_rst got st=%0d cnt=%0d exp 0 0", state, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    @(posedge clk); #1;
    checks++;
    if (state !== 2'd0 || ctl() !== 8'b11111_000) begin
      errors++; $display("FAIL wait_post_rst got st=%0d ctl=%b", state, ctl());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use();
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF || pc_en !== 1'b0) begin
      errors++; $display("FAIL saturation got cnt=%h pc_en=%0b exp ffff 0", stall_cnt, pc_en);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_boundary();
    test_async_rst_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
